// File: rtl/tybec_axis_pkg.sv
// rtl/tybec_axis_pkg.sv - shared TyBEC stream widths and channel defaults for the join/fork wrappers
package tybec_axis_pkg;

    localparam int TY_GVECT        = 1;
    localparam int TY_STREAMW      = 32 * TY_GVECT;
    localparam int TY_NUM_CHANNELS = 4;

    typedef logic [TY_STREAMW-1:0] ty_word_t;

    // A 1-beat packet still needs a 1-bit counter so the compare logic stays legal.
    function automatic int ty_cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/tybec_axis_fork_if.sv
// rtl/tybec_axis_fork_if.sv - kernel output bundle plus forked AXI channels (m_tlast with TY_FORK_TLAST_EN)
interface tybec_axis_fork_if
    import tybec_axis_pkg::*;
#(
    parameter int C_DATA_WIDTH   = TY_STREAMW,
    parameter int C_NUM_CHANNELS = TY_NUM_CHANNELS
);

    logic                                          s_ovalid;
    logic                                          s_oready;
    logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]   s_odata;
    logic [C_NUM_CHANNELS-1:0]                     m_tvalid;
    logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]   m_tdata;
    logic [C_NUM_CHANNELS-1:0]                     m_tready;
`ifdef TY_FORK_TLAST_EN
    logic [C_NUM_CHANNELS-1:0]                     m_tlast;
`endif

    // master: the fork itself, which masters every AXI output channel
    modport master (
        input  s_ovalid,
        input  s_odata,
        output s_oready,
        output m_tvalid,
        output m_tdata,
`ifdef TY_FORK_TLAST_EN
        output m_tlast,
`endif
        input  m_tready
    );

    modport slave (
        output s_ovalid,
        output s_odata,
        input  s_oready,
        input  m_tvalid,
        input  m_tdata,
`ifdef TY_FORK_TLAST_EN
        input  m_tlast,
`endif
        output m_tready
    );

endinterface

// File: rtl/tybec_axis_out_slot.sv
// rtl/tybec_axis_out_slot.sv - one forked channel's data/pend (and tlast with TY_FORK_TLAST_EN) register
module tybec_axis_out_slot
    import tybec_axis_pkg::*;
#(
    parameter int C_DATA_WIDTH = TY_STREAMW
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    load,
    input  logic [C_DATA_WIDTH-1:0] din,
    input  logic                    tready,
`ifdef TY_FORK_TLAST_EN
    input  logic                    last_in,
    output logic                    tlast,
`endif
    output logic                    tvalid,
    output logic [C_DATA_WIDTH-1:0] tdata,
    output logic                    free
);

    logic                    pend_q;
    logic [C_DATA_WIDTH-1:0] data_q;

    // A load wins over a drain so a slot emptied this cycle refills without a bubble.
    always_ff @(posedge aclk) begin
        if (areset) begin
            pend_q <= 1'b0;
            data_q <= '0;
        end else if (load) begin
            pend_q <= 1'b1;
            data_q <= din;
        end else if (pend_q && tready) begin
            pend_q <= 1'b0;
        end
    end

`ifdef TY_FORK_TLAST_EN
    logic tlast_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            tlast_q <= 1'b0;
        end else if (load) begin
            tlast_q <= last_in;
        end
    end

    assign tlast = tlast_q;
`endif

    assign tvalid = pend_q;
    assign tdata  = data_q;
    assign free   = !pend_q || tready;

endmodule

// File: rtl/tybec_axis_fork.sv
// rtl/tybec_axis_fork.sv - forks the kernel ovalid/oready bundle into N aligned AXI-stream masters (TY_FORK_TLAST_EN adds m_tlast)
module tybec_axis_fork
    import tybec_axis_pkg::*;
#(
    parameter int C_DATA_WIDTH   = TY_STREAMW,
    parameter int C_NUM_CHANNELS = TY_NUM_CHANNELS,
    parameter int C_PKT_LEN      = 1024
) (
    input  logic                  aclk,
    input  logic                  areset,
    tybec_axis_fork_if.master     bus
);

    if (C_NUM_CHANNELS < 1 || C_NUM_CHANNELS > 16 || C_PKT_LEN < 1) begin : g_bad_cfg
        $error("tybec_axis_fork: illegal C_NUM_CHANNELS or C_PKT_LEN");
    end

    logic [C_NUM_CHANNELS-1:0]                   free;
    logic [C_NUM_CHANNELS-1:0]                   tvalid;
    logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0] tdata;
    logic                                        oready;
    logic                                        accept;

    // Only free slots and reset gate the kernel; s_ovalid never feeds back into s_oready.
    always_comb begin
        oready = (&free) && !areset;
    end

    assign accept        = bus.s_ovalid && oready;
    assign bus.s_oready  = oready;
    assign bus.m_tvalid  = tvalid;
    assign bus.m_tdata   = tdata;

`ifdef TY_FORK_TLAST_EN
    localparam int CW = ty_cnt_width(C_PKT_LEN);

    logic [CW-1:0]             beat_q;
    logic                      last_beat;
    logic [C_NUM_CHANNELS-1:0] tlast;

    assign last_beat   = (beat_q == CW'(C_PKT_LEN - 1));
    assign bus.m_tlast = tlast;

    always_ff @(posedge aclk) begin
        if (areset) begin
            beat_q <= '0;
        end else if (accept) begin
            beat_q <= last_beat ? '0 : beat_q + 1'b1;
        end
    end
`endif

    for (genvar i = 0; i < C_NUM_CHANNELS; i++) begin : g_slot
        tybec_axis_out_slot #(
            .C_DATA_WIDTH (C_DATA_WIDTH)
        ) u_slot (
            .aclk    (aclk),
            .areset  (areset),
            .load    (accept),
            .din     (bus.s_odata[i]),
            .tready  (bus.m_tready[i]),
`ifdef TY_FORK_TLAST_EN
            .last_in (last_beat),
            .tlast   (tlast[i]),
`endif
            .tvalid  (tvalid[i]),
            .tdata   (tdata[i]),
            .free    (free[i])
        );
    end

endmodule

// File: tb/tb_tybec_axis_fork.sv
// tb/tb_tybec_axis_fork.sv - directed and random bench for tybec_axis_fork (TLAST steps under TY_FORK_TLAST_EN)
module tb_tybec_axis_fork;

    localparam int W = 32;
    localparam int N = 4;
    localparam int NBEATS = 2000;
    localparam int CYC_LIMIT = 40000;

    logic aclk;
    logic areset;
    int   total;
    int   passes;

    tybec_axis_fork_if #(.C_DATA_WIDTH(W), .C_NUM_CHANNELS(N)) bus ();

    tybec_axis_fork #(
        .C_DATA_WIDTH   (W),
        .C_NUM_CHANNELS (N),
        .C_PKT_LEN      (4)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    logic [31:0] exp_w;
    logic [3:0]  mpend;
    logic [3:0]  prev_hold;
    logic [31:0] prev_data [N];
    logic [31:0] q [N][$];
    logic        exp_or;
    int          sent;
    int          cyc;

    initial begin
        total = 0;
        passes = 0;
        areset = 1'b1;
        bus.s_ovalid = 1'b0;
        bus.s_odata = '0;
        bus.m_tready = '0;

        // reset state
        tick();
        tick();
        #1;
        chk("rst_oready", bus.s_oready, 0);
        chk("rst_tvalid", bus.m_tvalid, 0);
        for (int i = 0; i < N; i++) chk($sformatf("rst_tdata%0d", i), bus.m_tdata[i], 0);
        areset = 1'b0;
        bus.m_tready = 4'hF;
        #1;
        chk("idle_oready", bus.s_oready, 1);
        tick();
        chk("idle_ready_no_effect", bus.m_tvalid, 0);

        // 8 beats, all ready
        for (int k = 1; k <= 8; k++) begin
            bus.s_ovalid = 1'b1;
            for (int i = 0; i < N; i++) bus.s_odata[i] = 32'h100 * i + k;
            #1;
            chk($sformatf("t1_oready_k%0d", k), bus.s_oready, 1);
            tick();
            chk($sformatf("t1_tvalid_k%0d", k), bus.m_tvalid, 4'hF);
            for (int i = 0; i < N; i++) begin
                exp_w = 32'h100 * i + k;
                chk($sformatf("t1_tdata%0d_k%0d", i, k), bus.m_tdata[i], exp_w);
            end
        end
        bus.s_ovalid = 1'b0;
        tick();
        chk("t1_drained", bus.m_tvalid, 0);

        // channel 2 stalled for a while
        bus.s_ovalid = 1'b1;
        for (int i = 0; i < N; i++) bus.s_odata[i] = 32'hA0 + i;
        #1;
        chk("t2_oready_a", bus.s_oready, 1);
        tick();
        bus.m_tready = 4'b1011;
        for (int i = 0; i < N; i++) bus.s_odata[i] = 32'hB0 + i;
        #1;
        chk("t2_oready_stall0", bus.s_oready, 0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk($sformatf("t2_tvalid_stall%0d", c), bus.m_tvalid, 4'b0100);
            chk($sformatf("t2_tdata2_stall%0d", c), bus.m_tdata[2], 32'hA2);
            chk($sformatf("t2_oready_stall%0d", c + 1), bus.s_oready, 0);
        end
        bus.m_tready = 4'hF;
        #1;
        chk("t2_oready_release", bus.s_oready, 1);
        tick();
        chk("t2_tvalid_b", bus.m_tvalid, 4'hF);
        for (int i = 0; i < N; i++) begin
            exp_w = 32'hB0 + i;
            chk($sformatf("t2_tdata%0d_b", i), bus.m_tdata[i], exp_w);
        end
        bus.s_ovalid = 1'b0;
        tick();
        chk("t2_drained", bus.m_tvalid, 0);

        // all stalled: one beat held
        bus.m_tready = 4'h0;
        bus.s_ovalid = 1'b1;
        for (int i = 0; i < N; i++) bus.s_odata[i] = 32'hDEADBEEF;
        #1;
        chk("t3_oready_first", bus.s_oready, 1);
        tick();
        for (int i = 0; i < N; i++) bus.s_odata[i] = 32'h12345678;
        #1;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("t3_oready_c%0d", c), bus.s_oready, 0);
            chk($sformatf("t3_tvalid_c%0d", c), bus.m_tvalid, 4'hF);
            for (int i = 0; i < N; i++)
                chk($sformatf("t3_tdata%0d_c%0d", i, c), bus.m_tdata[i], 32'hDEADBEEF);
            tick();
        end

        // reset with every slot pending
        areset = 1'b1;
        #1;
        chk("t4_oready_in_reset", bus.s_oready, 0);
        tick();
        chk("t4_tvalid_after", bus.m_tvalid, 0);
        chk("t4_oready_after", bus.s_oready, 0);
        for (int i = 0; i < N; i++) chk($sformatf("t4_tdata%0d", i), bus.m_tdata[i], 0);
        areset = 1'b0;
        bus.s_ovalid = 1'b0;
        #1;
        chk("t4_oready_release", bus.s_oready, 1);

`ifdef TY_FORK_TLAST_EN
        // packet length 4: last on beats 4 and 8, counter wraps into beat 9
        bus.m_tready = 4'hF;
        for (int k = 1; k <= 9; k++) begin
            bus.s_ovalid = 1'b1;
            for (int i = 0; i < N; i++) bus.s_odata[i] = 32'h200 + k;
            tick();
            chk($sformatf("t5_tvalid_k%0d", k), bus.m_tvalid, 4'hF);
            chk($sformatf("t5_tlast_k%0d", k), bus.m_tlast, (k % 4 == 0) ? 4'hF : 4'h0);
        end
        bus.s_ovalid = 1'b0;
        tick();
`endif

        // random back-pressure and source gaps against a scoreboard
        bus.s_ovalid = 1'b0;
        bus.m_tready = 4'hF;
        tick();
        tick();
        mpend = '0;
        prev_hold = '0;
        sent = 0;
        cyc = 0;
        while ((sent < NBEATS || mpend != 0) && cyc < CYC_LIMIT) begin
            for (int i = 0; i < N; i++) begin
                if (prev_hold[i]) begin
                    chk($sformatf("r_hold_valid%0d", i), bus.m_tvalid[i], 1);
                    chk($sformatf("r_hold_data%0d", i), bus.m_tdata[i], prev_data[i]);
                end
            end
            chk("r_tvalid", bus.m_tvalid, mpend);
            bus.m_tready = 4'($urandom);
            bus.s_ovalid = (sent < NBEATS) && ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) bus.s_odata[i] = $urandom;
            #1;
            exp_or = &(~mpend | bus.m_tready);
            chk("r_oready", bus.s_oready, exp_or);
            for (int i = 0; i < N; i++) begin
                if (bus.m_tvalid[i] && bus.m_tready[i]) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("r_dup%0d", i), 1, 0);
                    end else begin
                        exp_w = q[i].pop_front();
                        chk($sformatf("r_order%0d", i), bus.m_tdata[i], exp_w);
                    end
                end
                prev_hold[i] = bus.m_tvalid[i] && !bus.m_tready[i];
                prev_data[i] = bus.m_tdata[i];
            end
            if (bus.s_ovalid && exp_or) begin
                for (int i = 0; i < N; i++) q[i].push_back(bus.s_odata[i]);
                mpend = 4'hF;
                sent++;
            end else begin
                mpend = mpend & ~bus.m_tready;
            end
            tick();
            cyc++;
        end
        chk("r_timeout", (cyc < CYC_LIMIT), 1);
        chk("r_sent", sent, NBEATS);
        for (int i = 0; i < N; i++) chk($sformatf("r_lost%0d", i), q[i].size(), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/tybec_axis_fork.md
Name: tybec_axis_fork

Overview:
- Output-side counterpart of the kernel input wrapper, which joins several AXI-stream slave channels into one ivalid/iready bundle.
- This block forks the generated kernel's single ovalid/oready output bundle (N parallel result streams) into N independent AXI-stream master channels, each with its own tvalid/tready.
- Sits between the TyBEC kernel "main" outputs and the AXI output channels of the top-level wrapper.

Parameters:
- C_DATA_WIDTH, 32, width of one output stream word (32 * TY_GVECT).
- C_NUM_CHANNELS, 4, number of forked output channels (1..16).
- C_PKT_LEN, 1024, beats per packet; used only when TY_FORK_TLAST_EN is defined; legal range >= 1.

Ports:
- aclk  in  1  clock.
- areset  in  1  reset, synchronous, active-high.
- s_ovalid  in  1  kernel output bundle valid (from main ovalid).
- s_oready  out  1  back-pressure to kernel (to main oready).
- s_odata  in  [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  kernel output words, one per stream.
- m_tvalid  out  [C_NUM_CHANNELS-1:0]  per-channel AXI valid.
- m_tdata  out  [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  per-channel AXI data.
- m_tready  in  [C_NUM_CHANNELS-1:0]  per-channel AXI ready.
- m_tlast  out  [C_NUM_CHANNELS-1:0]  per-channel end of packet; present only with TY_FORK_TLAST_EN.

Behaviour:
- One clock, aclk. Reset is synchronous and active-high on areset.
- Per-channel state: data_q[i] (C_DATA_WIDTH), pend_q[i] (1 bit).
- Reset values: pend_q=0, data_q=0, m_tvalid=0, m_tdata=0, m_tlast=0.
- s_oready is forced to 0 while areset is high.
- Output assignments: m_tvalid[i]=pend_q[i]; m_tdata[i]=data_q[i].
- free[i] = !pend_q[i] | m_tready[i].
- s_oready = &free & !areset.
- s_oready is combinational from m_tready and registered state only, never from s_ovalid.
- Accept = s_ovalid & s_oready. On accept, all data_q[i] load s_odata[i] and all pend_q[i] set to 1. A channel being drained in the same cycle is reloaded; no bubble.
- Without accept: pend_q[i] clears when m_tready[i] & pend_q[i]. data_q[i] holds.
- Latency: 1 cycle from accept to m_tvalid.
- Throughput: 1 beat/cycle when all m_tready are high.
- AXI rules:
  - Once m_tvalid[i] rises, it and m_tdata[i] stay stable until m_tready[i].
  - m_tvalid never depends combinationally on m_tready.
- Alignment: beat k on every channel carries the kernel's k-th output. A channel that handshakes early idles (tvalid low) until the slowest channel drains; the next beat is accepted only then.
- Channel skew is bounded to 1 beat; no beat is lost or duplicated.
- Boundary conditions:
  - All channels stalled: one beat is held, s_oready=0.
  - A single stalled channel blocks the whole fork.
  - Reset mid-operation discards pending beats; m_tvalid=0 in the cycle after areset is sampled.
  - m_tready high with pend_q=0 has no effect.

Optional Feature:
- Macro TY_FORK_TLAST_EN.
- Defined:
  - Counter beat_q, width $clog2(C_PKT_LEN) (minimum 1), reset 0, increments on accept.
  - Wraps to 0 after the accept at C_PKT_LEN-1.
  - tlast_q[i] loads (beat_q==C_PKT_LEN-1) on accept and holds with data.
  - m_tlast[i]=tlast_q[i]. With C_PKT_LEN=1 every beat is last.
- Undefined: no counter, no m_tlast port, no TLAST logic.

Decomposition:
- Package tybec_axis_pkg holds:
  - TY_GVECT-derived constant TY_STREAMW = 32*TY_GVECT.
  - Typedef ty_word_t (logic [TY_STREAMW-1:0]).
  - Default channel count constant; shared by the input join wrapper and this block.
- Sub-module tybec_axis_out_slot: one channel's data/pend/tlast register with a load/drain interface, instantiated C_NUM_CHANNELS times via generate. The fork top holds the free-AND reduction and the beat counter.

Test Plan:
- All m_tready=1; 8 accepted beats, channel i word = 0x100*i + k (k=1..8): each m_tdata[i] shows the 8 words on 8 consecutive cycles, 1 cycle after each accept; s_oready stays 1.
- m_tready[2]=0 for cycles 3-5, others 1, continuous s_ovalid:
  - Channels 0, 1, 3 deliver the current beat once, then tvalid=0.
  - s_oready=0 during the stall.
  - Next beat accepted the cycle m_tready[2] returns; scoreboard shows no loss or duplication.
- All m_tready=0, s_ovalid=1 with 0xDEADBEEF on every channel: captured once; s_oready=0 afterwards; m_tdata stays 0xDEADBEEF and m_tvalid stays 1 for 10 cycles.
- areset pulsed while pend_q=all ones and m_tready=0: s_oready=0 during reset; m_tvalid=0 and m_tdata=0 from the following cycle.
- TY_FORK_TLAST_EN, C_PKT_LEN=4, 9 beats with all ready: m_tlast high on beats 4 and 8 only; counter wraps.
- 2000 beats with independent random m_tready (50%) and random s_ovalid gaps:
  - Per-channel output order matches input order.
  - AXI stability assertions hold throughout.
